// File: rtl/alu_divider.sv
// rtl/alu_divider.sv - signed radix-2 restoring divider, one quotient bit per cycle
// Magnitudes are divided unsigned; signs are reapplied on the way out while in DONE.
module alu_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             op_start,
  input  logic             op_clear,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             op_done
);

  localparam int          CNT_W  = $clog2(WIDTH);
  localparam logic [1:0]  S_IDLE = 2'b00;
  localparam logic [1:0]  S_EXEC = 2'b01;
  localparam logic [1:0]  S_DONE = 2'b10;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] p_q, p_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dz_q, dz_d;

  logic [WIDTH:0]   p_shift;
  logic [WIDTH:0]   diff;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      p_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      p_q       <= p_d;
      q_q       <= q_d;
      d_q       <= d_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
    end
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE: state_d = (op_start && !op_clear) ? S_EXEC : S_IDLE;
      S_EXEC: begin
        if (op_clear)               state_d = S_IDLE;
        else if (cnt_q == CNT_LAST) state_d = S_DONE;
        else                        state_d = S_EXEC;
      end
      S_DONE: state_d = op_clear ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Shifted partial remainder is one bit wider so the borrow of P - D survives.
  always_comb begin
    p_shift   = {p_q, q_q[WIDTH-1]};
    diff      = p_shift - {1'b0, d_q};
    cnt_d     = cnt_q;
    p_d       = p_q;
    q_d       = q_q;
    d_d       = d_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    if (op_clear || state_q == 2'b11) begin
      cnt_d     = '0;
      p_d       = '0;
      q_d       = '0;
      d_d       = '0;
      neg_quo_d = 1'b0;
      neg_rem_d = 1'b0;
      dz_d      = 1'b0;
    end else if (state_q == S_IDLE && op_start) begin
      cnt_d     = '0;
      p_d       = '0;
      q_d       = dividend[WIDTH-1] ? -dividend : dividend;
      d_d       = divisor[WIDTH-1] ? -divisor : divisor;
      neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_rem_d = dividend[WIDTH-1];
      dz_d      = (divisor == '0);
    end else if (state_q == S_EXEC) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (!diff[WIDTH]) begin
        p_d = diff[WIDTH-1:0];
        q_d = {q_q[WIDTH-2:0], 1'b1};
      end else begin
        p_d = p_shift[WIDTH-1:0];
        q_d = {q_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  // With a zero divisor every step succeeds, so P ends up as |dividend| and
  // the signed remainder is the sampled dividend without a separate mux.
  always_comb begin
    op_done     = (state_q == S_DONE);
    quotient    = '0;
    remainder   = '0;
    div_by_zero = 1'b0;
    if (op_done) begin
      quotient    = dz_q ? '1 : (neg_quo_q ? -q_q : q_q);
      remainder   = neg_rem_q ? -p_q : p_q;
      div_by_zero = dz_q;
    end
  end

endmodule

// File: tb/tb_alu_divider.sv
// tb/tb_alu_divider.sv - randomized and directed checks of alu_divider against a behavioural model
module tb_alu_divider;
  localparam int W = 32;
  localparam logic [W-1:0] MIN_V = 32'h8000_0000;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         op_start = 1'b0;
  logic         op_clear = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         op_done;

  int vectors = 0;
  int miscompares = 0;

  alu_divider #(.WIDTH(W)) dut (
    .clk(clk), .reset_n(reset_n), .op_start(op_start), .op_clear(op_clear),
    .dividend(dividend), .divisor(divisor), .quotient(quotient),
    .remainder(remainder), .div_by_zero(div_by_zero), .op_done(op_done)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_quo(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    if (b == '0) return '1;
    return W'(sa / sb);
  endfunction

  function automatic logic [W-1:0] ref_rem(input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    if (b == '0) return a;
    return W'(sa % sb);
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: phase 0 idle, 1 busy with a countdown of edges, 2 result presented.
  int           m_phase = 0;
  int           m_rem = 0;
  logic [W-1:0] m_q = '0;
  logic [W-1:0] m_r = '0;
  logic         m_dz = 1'b0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_phase <= 0;
    end else if (op_clear) begin
      m_phase <= 0;
    end else if (m_phase == 0) begin
      if (op_start) begin
        m_q     <= ref_quo(dividend, divisor);
        m_r     <= ref_rem(dividend, divisor);
        m_dz    <= (divisor == '0);
        m_rem   <= W;
        m_phase <= 1;
      end
    end else if (m_phase == 1) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) m_phase <= 2;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      check("op_done", {31'b0, op_done}, {31'b0, m_phase == 2});
      check("quotient", quotient, (m_phase == 2) ? m_q : '0);
      check("remainder", remainder, (m_phase == 2) ? m_r : '0);
      check("div_by_zero", {31'b0, div_by_zero}, {31'b0, (m_phase == 2) && m_dz});
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold_start,
                       output int lat);
    int n;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    op_start = 1'b1;
    @(negedge clk);
    if (!hold_start) op_start = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    n = 0;
    while (!op_done && n < 200) begin
      @(negedge clk);
      n++;
    end
    lat = n;
  endtask

  task automatic clear_op();
    @(negedge clk);
    op_clear = 1'b1;
    op_start = 1'b0;
    @(negedge clk);
    op_clear = 1'b0;
  endtask

  task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz);
    int lat;
    do_op(a, b, 1'b0, lat);
    check({name, "_latency"}, W'(lat), W'(32));
    check({name, "_q"}, quotient, eq);
    check({name, "_r"}, remainder, er);
    check({name, "_dz"}, {31'b0, div_by_zero}, {31'b0, edz});
    clear_op();
  endtask

  task automatic start_abort(input logic [W-1:0] a, input logic [W-1:0] b, input int k);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    repeat (k - 1) @(negedge clk);
    op_clear = 1'b1;
    @(negedge clk);
    op_clear = 1'b0;
    check("abort_done", {31'b0, op_done}, '0);
    check("abort_q", quotient, '0);
  endtask

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return MIN_V;
      2: return '1;
      3: return 32'd1;
      4: return W'($urandom_range(0, 200)) - 32'd100;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    check("reset_q", quotient, '0);
    check("reset_done", {31'b0, op_done}, '0);
    reset_n = 1'b1;

    directed("pos", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    directed("negdvd", -32'd100, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
    directed("negdvs", 32'd100, -32'd7, -32'd14, 32'd2, 1'b0);
    directed("ovf", MIN_V, 32'hFFFF_FFFF, MIN_V, 32'd0, 1'b0);
    directed("min1", MIN_V, 32'd1, MIN_V, 32'd0, 1'b0);
    directed("dz", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1);
    directed("dzneg", -32'd9, 32'd0, 32'hFFFF_FFFF, -32'd9, 1'b1);

    start_abort(32'd123456, 32'd789, 10);
    directed("restart", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

    // Clear and start together in IDLE: clear wins, nothing runs.
    @(negedge clk);
    op_start = 1'b1;
    op_clear = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    op_clear = 1'b0;
    repeat (35) @(negedge clk);
    check("startclr_done", {31'b0, op_done}, '0);

    // Async reset in EXEC, then in DONE.
    @(negedge clk);
    dividend = 32'd1000;
    divisor  = 32'd3;
    op_start = 1'b1;
    @(negedge clk);
    op_start = 1'b0;
    repeat (19) @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1 check("rst_exec_done", {31'b0, op_done}, '0);
    @(negedge clk);
    reset_n = 1'b1;
    do_op(32'd77, 32'd5, 1'b0, lat);
    check("pre_rst_q", quotient, 32'd15);
    #2 reset_n = 1'b0;
    #1 check("rst_done_q", quotient, '0);
    check("rst_done_r", remainder, '0);
    @(negedge clk);
    reset_n = 1'b1;

    // op_start held through DONE: result stays until clear.
    do_op(32'd100, 32'd7, 1'b1, lat);
    repeat (5) @(negedge clk);
    check("hold_q", quotient, 32'd14);
    check("hold_r", remainder, 32'd2);
    clear_op();

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        start_abort($urandom, $urandom, $urandom_range(1, 31));
      end else begin
        do_op(pick_operand(), pick_operand(), 1'b0, lat);
        check("rand_latency", W'(lat), W'(32));
        repeat ($urandom_range(0, 2)) @(negedge clk);
        clear_op();
      end
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
